// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I controller: opcodes, FSM states,
// write-back select codes, branch funct3 codes and small decode helpers.
package riscv_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd7
    } state_e;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_AUIPC,
        CLS_LUI,
        CLS_ILLEGAL
    } opc_class_e;

    function automatic opc_class_e decode_class(input logic [6:0] opcode);
        opc_class_e cls;
        case (opcode)
            OPC_OP:     cls = CLS_R;
            OPC_OP_IMM: cls = CLS_I;
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_BRANCH: cls = CLS_BRANCH;
            OPC_JAL:    cls = CLS_JAL;
            OPC_JALR:   cls = CLS_JALR;
            OPC_AUIPC:  cls = CLS_AUIPC;
            OPC_LUI:    cls = CLS_LUI;
            default:    cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

    // funct3 010/011 are unassigned for branches; unlisted codes read as not-taken.
    function automatic logic branch_f3_legal(input logic [2:0] funct3);
        return (funct3 != 3'b010) && (funct3 != 3'b011);
    endfunction

    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic       less,
                                          input logic       equal);
        logic taken;
        case (funct3)
            F3_BEQ:           taken = equal;
            F3_BNE:           taken = !equal;
            F3_BLT, F3_BLTU:  taken = less;
            F3_BGE, F3_BGEU:  taken = !less;
            default:          taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory-wait watchdog shared by the FETCH and MEM request states: counts
// un-acked request cycles, saturates, and flags the last permitted cycle.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMR_W       = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_active,
    input  logic i_ack,
    input  logic i_clear,
    output logic o_timeout
);

    localparam logic [TMR_W-1:0] LIMIT = TMR_W'(MEM_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] SAT   = '1;

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (!i_clear && i_active && !i_ack) begin
            cnt_d = (cnt_q == SAT) ? cnt_q : cnt_q + TMR_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // An ack in the final cycle takes precedence over the timeout.
    assign o_timeout = i_active && !i_ack && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I core with a
// sticky TRAP state. Define MCYC_INSTRET_EN to add the o_instret retire counter.
module multicycle_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMR_W       = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_instr,
    input  logic        i_imem_ack,
    input  logic        i_dmem_ack,
    input  logic        i_br_less,
    input  logic        i_br_equal,
    output logic        o_imem_req,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic        o_ir_en,
    output logic        o_pc_en,
    output logic        o_pc_sel,
    output logic        o_reg_wen,
    output logic        o_asel,
    output logic        o_bsel,
    output logic        o_br_un,
    output logic [1:0]  o_wb_sel,
    output logic        o_trap,
    output logic [2:0]  o_state
`ifdef MCYC_INSTRET_EN
    ,
    output logic [31:0] o_instret
`endif
);

    state_e     state_q;
    state_e     state_d;
    opc_class_e cls;
    logic [2:0] funct3;
    logic       taken;
    logic       req_active;
    logic       req_ack;
    logic       timeout;
    logic       unused_instr;

    assign funct3       = i_instr[14:12];
    assign cls          = decode_class(i_instr[6:0]);
    assign taken        = branch_taken(funct3, i_br_less, i_br_equal);
    assign unused_instr = ^{i_instr[31:15], i_instr[11:7]};

    assign req_active = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign req_ack    = ((state_q == ST_FETCH) && i_imem_ack) ||
                        ((state_q == ST_MEM)   && i_dmem_ack);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TMR_W       (TMR_W)
    ) u_mem_wait_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_active  (req_active),
        .i_ack     (req_ack),
        .i_clear   (state_d != state_q),
        .o_timeout (timeout)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:   state_d = ST_FETCH;
            ST_FETCH: begin
                if (i_imem_ack) begin
                    state_d = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_TRAP;
                end
            end
            ST_DECODE: begin
                if ((cls == CLS_ILLEGAL) ||
                    ((cls == CLS_BRANCH) && !branch_f3_legal(funct3))) begin
                    state_d = ST_TRAP;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (cls)
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    CLS_BRANCH:          state_d = ST_FETCH;
                    default:             state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (i_dmem_ack) begin
                    state_d = (cls == CLS_STORE) ? ST_FETCH : ST_WB;
                end else if (timeout) begin
                    state_d = ST_TRAP;
                end
            end
            ST_WB:     state_d = ST_FETCH;
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_TRAP;
        endcase
    end

    // Outputs decode from the state register and IR; only o_ir_en and the
    // store-retire PC strobe look at the current-cycle ack.
    always_comb begin
        o_imem_req = 1'b0;
        o_dmem_req = 1'b0;
        o_dmem_we  = 1'b0;
        o_ir_en    = 1'b0;
        o_pc_en    = 1'b0;
        o_pc_sel   = 1'b0;
        o_reg_wen  = 1'b0;
        o_asel     = 1'b0;
        o_bsel     = 1'b0;
        o_br_un    = 1'b0;
        o_wb_sel   = WB_MEM;
        o_trap     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                o_imem_req = 1'b1;
                o_ir_en    = i_imem_ack;
            end
            ST_EXEC: begin
                case (cls)
                    CLS_R: begin
                        o_asel = 1'b0;
                        o_bsel = 1'b0;
                    end
                    CLS_I, CLS_LOAD, CLS_STORE, CLS_JALR: begin
                        o_bsel = 1'b1;
                    end
                    CLS_BRANCH: begin
                        o_asel   = 1'b1;
                        o_bsel   = 1'b1;
                        o_pc_en  = 1'b1;
                        o_pc_sel = taken;
                        o_br_un  = funct3[1];
                    end
                    CLS_JAL, CLS_AUIPC, CLS_LUI: begin
                        o_asel = 1'b1;
                        o_bsel = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                o_dmem_req = 1'b1;
                o_dmem_we  = (cls == CLS_STORE);
                o_bsel     = 1'b1;
                o_pc_en    = i_dmem_ack && (cls == CLS_STORE);
            end
            ST_WB: begin
                o_reg_wen = 1'b1;
                o_pc_en   = 1'b1;
                o_pc_sel  = (cls == CLS_JAL) || (cls == CLS_JALR);
                case (cls)
                    CLS_LOAD:                 o_wb_sel = WB_MEM;
                    CLS_R, CLS_I, CLS_AUIPC:  o_wb_sel = WB_ALU;
                    CLS_JAL, CLS_JALR:        o_wb_sel = WB_PC4;
                    CLS_LUI:                  o_wb_sel = WB_IMM;
                    default:                  o_wb_sel = WB_MEM;
                endcase
            end
            ST_TRAP: begin
                o_trap = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_state = state_q;

`ifdef MCYC_INSTRET_EN
    logic [31:0] instret_q;
    logic [31:0] instret_d;

    always_comb begin
        instret_d = instret_q;
        if (o_pc_en && (state_q != ST_TRAP)) begin
            instret_d = instret_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign o_instret = instret_q;
`endif

endmodule
